// File: rtl/proc_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_cmd_sequencer_pkg
// Brief    : Shared types and field constants for the command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package proc_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam int c_CMD_W = $bits(cmd_t);
    localparam int c_RSP_W = 9;

    // addr[7:6] selects the I2C device, addr[5:0] the memory location inside it
    localparam int c_DEV_ADDR_MSB = 7;
    localparam int c_DEV_ADDR_LSB = 6;
    localparam int c_MEM_ADDR_MSB = 5;
    localparam int c_MEM_ADDR_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO; a push while full is refused even on a pop.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : proc_cmd_sequencer
// Brief    : Queues bus commands, issues them one at a time to the APB master
//            and returns read data (or a timeout marker) through a response queue.
// Revision : 1.0 - initial release
// ============================================================================
module proc_cmd_sequencer
    import proc_cmd_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       pb_write,
    output logic       pb_start,
    output logic [1:0] pb_sel,
    output logic [7:0] pb_addr,
    output logic [7:0] pb_wdata,
    input  logic       pb_done,
    input  logic [7:0] pb_rdata,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);
    localparam logic [1:0] c_IDLE    = ST_IDLE;
    localparam logic [1:0] c_ISSUE   = ST_ISSUE;
    localparam logic [1:0] c_WAIT    = ST_WAIT;
    localparam logic [1:0] c_RELEASE = ST_RELEASE;
    localparam int         c_CMD_CW  = $clog2(CMD_DEPTH + 1);
    localparam int         c_RSP_CW  = $clog2(RSP_DEPTH + 1);

    logic [1:0]          r_state;
    logic [7:0]          r_wait_cnt;
    logic [7:0]          r_rdata;
    logic                r_fail;
    logic                r_err_timeout;
    logic                r_pb_write;
    logic                r_pb_start;
    logic [1:0]          r_pb_sel;
    logic [7:0]          r_pb_addr;
    logic [7:0]          r_pb_wdata;

    cmd_t                w_cmd_in;
    cmd_t                w_cmd_head;
    logic [c_CMD_W-1:0]  w_cmd_rdata;
    logic                w_cmd_full;
    logic                w_cmd_empty;
    logic                w_cmd_pop;
    logic [c_CMD_CW-1:0] w_cmd_count;
    logic [c_RSP_W-1:0]  w_rsp_wdata;
    logic [c_RSP_W-1:0]  w_rsp_rdata;
    logic                w_rsp_push;
    logic                w_rsp_full;
    logic                w_rsp_empty;
    logic [c_RSP_CW-1:0] w_rsp_count;
    logic [7:0]          w_cnt_next;
    logic                w_timeout;
    logic                w_can_issue;

    assign w_cmd_in   = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr, wdata: cmd_wdata};
    assign w_cmd_head = cmd_t'(w_cmd_rdata);
    assign w_cmd_pop  = (r_state == c_ISSUE);

    sync_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .pop     (w_cmd_pop),
        .wdata   (w_cmd_in),
        .rdata   (w_cmd_rdata),
        .full    (w_cmd_full),
        .empty   (w_cmd_empty),
        .count   (w_cmd_count)
    );

    // A read never enters the bus unless its response is guaranteed a slot
    assign w_can_issue = !w_cmd_empty && (w_cmd_head.write || !w_rsp_full);
    assign w_cnt_next  = r_wait_cnt + 8'd1;
    assign w_timeout   = (r_state == c_WAIT) && !pb_done && (w_cnt_next == 8'(TIMEOUT));

    assign w_rsp_push  = (r_state == c_RELEASE) && !r_pb_write;
    assign w_rsp_wdata = {(r_fail ? 8'hFF : r_rdata), r_fail};

    sync_fifo #(
        .WIDTH (c_RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_rsp_push),
        .pop     (rsp_ready),
        .wdata   (w_rsp_wdata),
        .rdata   (w_rsp_rdata),
        .full    (w_rsp_full),
        .empty   (w_rsp_empty),
        .count   (w_rsp_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_wait_cnt    <= 8'd0;
            r_rdata       <= 8'd0;
            r_fail        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_pb_write    <= 1'b0;
            r_pb_start    <= 1'b0;
            r_pb_sel      <= 2'd0;
            r_pb_addr     <= 8'd0;
            r_pb_wdata    <= 8'd0;
        end else begin
            r_pb_start <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_can_issue) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_pb_start <= 1'b1;
                    r_pb_write <= w_cmd_head.write;
                    r_pb_sel   <= w_cmd_head.sel;
                    r_pb_addr  <= w_cmd_head.addr;
                    r_pb_wdata <= w_cmd_head.wdata;
                    r_wait_cnt <= 8'd0;
                    r_fail     <= 1'b0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    r_wait_cnt <= w_cnt_next;
                    // pb_done has priority so a reply on the final cycle is a success
                    if (pb_done) begin
                        if (!r_pb_write) begin
                            r_rdata <= pb_rdata;
                        end
                        r_pb_sel <= 2'd0;
                        r_state  <= c_RELEASE;
                    end else if (w_timeout) begin
                        r_fail   <= 1'b1;
                        r_pb_sel <= 2'd0;
                        r_state  <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    assign cmd_ready   = !w_cmd_full;
    assign rsp_valid   = !w_rsp_empty;
    assign {rsp_data, rsp_err} = (w_rsp_count != '0) ? w_rsp_rdata : '0;
    assign busy        = (r_state != c_IDLE) || (w_cmd_count != '0);
    assign err_timeout = r_err_timeout;
    assign pb_write    = r_pb_write;
    assign pb_start    = r_pb_start;
    assign pb_sel      = r_pb_sel;
    assign pb_addr     = r_pb_addr;
    assign pb_wdata    = r_pb_wdata;

endmodule
`default_nettype wire
